// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad model with LFSR contact bounce
module keypad_emulator #(
    parameter int          BOUNCE_CYCLES = 16,
    parameter int          GAP_CYCLES    = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cols,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] hold_cycles,
    output logic        key_ready,
    output logic        busy,
    output logic        contact,
    output logic [3:0]  rows
);

    localparam int BW = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BNC_LOAD = BW'(BOUNCE_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_B,
        S_HELD,
        S_REL_B,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_key;
    logic [3:0]    w_key_nxt;
    logic [15:0]   r_hold_cnt;
    logic [15:0]   w_hold_nxt;
    logic [BW-1:0] r_bnc_cnt;
    logic [BW-1:0] w_bnc_nxt;
    logic [GW-1:0] r_gap_cnt;
    logic [GW-1:0] w_gap_nxt;
    logic [7:0]    r_lfsr;
    logic [7:0]    w_lfsr_nxt;
    logic          r_contact;
    logic          w_contact_nxt;
    logic          w_bouncing;

    assign w_bouncing = (r_state == S_PRESS_B) || (r_state == S_REL_B);
    assign w_lfsr_nxt = w_bouncing ? {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]}
                                   : r_lfsr;

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_hold_nxt  = r_hold_cnt;
        w_bnc_nxt   = r_bnc_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (key_valid) begin
                    w_key_nxt  = key_code;
                    w_hold_nxt = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
                    if (BOUNCE_CYCLES > 0) begin
                        w_state_nxt = S_PRESS_B;
                        w_bnc_nxt   = BNC_LOAD;
                    end else begin
                        w_state_nxt = S_HELD;
                    end
                end
            end
            S_PRESS_B: begin
                if (r_bnc_cnt == BW'(1)) w_state_nxt = S_HELD;
                else                     w_bnc_nxt   = r_bnc_cnt - BW'(1);
            end
            S_HELD: begin
                if (r_hold_cnt == 16'd1) begin
                    if (BOUNCE_CYCLES > 0) begin
                        w_state_nxt = S_REL_B;
                        w_bnc_nxt   = BNC_LOAD;
                    end else if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt - 16'd1;
                end
            end
            S_REL_B: begin
                if (r_bnc_cnt == BW'(1)) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_bnc_nxt = r_bnc_cnt - BW'(1);
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GW'(1)) w_state_nxt = S_IDLE;
                else                     w_gap_nxt   = r_gap_cnt - GW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // contact is registered, so it is computed for the state being entered
        case (w_state_nxt)
            S_PRESS_B, S_REL_B: w_contact_nxt = w_lfsr_nxt[7];
            S_HELD:             w_contact_nxt = 1'b1;
            default:            w_contact_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_key      <= 4'd0;
            r_hold_cnt <= 16'd0;
            r_bnc_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_lfsr     <= LFSR_SEED;
            r_contact  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key      <= w_key_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_bnc_cnt  <= w_bnc_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_contact  <= w_contact_nxt;
        end
    end

    assign key_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign contact   = r_contact;
    // Passive switch: column drive reaches the row line combinationally.
    assign rows      = (r_contact && cols[r_key[3:2]]) ? (4'b0001 << r_key[1:0]) : 4'b0000;

endmodule
